// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, FSM state type and byte-level round helpers.
// Shared by aes_key_step and aes128_selfcheck.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DEC  = 2'd2
  } fsm_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    unique case (i)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      x2 = xtime(a[i]);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0] ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1] ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2] ^ m14[3]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes128_selfcheck_if.sv
// aes128_selfcheck_if: start request, operands and results of the
// self-check engine; master drives operands, slave returns results.
interface aes128_selfcheck_if;
  logic         enable;
  logic [127:0] in;
  logic [127:0] key128;
  logic [127:0] expected128;
  logic [127:0] decrypted128;
  logic [127:0] encrypted128;
  logic         e128;
  logic         d128;
  logic         busy;
  logic         done;

  modport master (
    output enable, in, key128, expected128,
    input  decrypted128, encrypted128, e128, d128, busy, done
  );

  modport slave (
    input  enable, in, key128, expected128,
    output decrypted128, encrypted128, e128, d128, busy, done
  );
endinterface

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key schedule step in both directions,
// so round keys can be walked forward and back without a key store.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] next_o,
  output logic [127:0] prev_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;

  assign w0 = rk_i[127:96];
  assign w1 = rk_i[95:64];
  assign w2 = rk_i[63:32];
  assign w3 = rk_i[31:0];

  // forward: rk_i is key r, next_o is key r+1 (rcon_i = Rcon[r])
  always_comb begin
    n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_o = {n0, n1, n2, n3};
  end

  // inverse: rk_i is key r+1, prev_o is key r (same rcon_i)
  always_comb begin
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon_i, 24'h0};
    prev_o = {p0, p1, p2, p3};
  end

endmodule

// File: rtl/aes128_selfcheck.sv
// aes128_selfcheck: one-round-per-clock AES-128 encrypt then decrypt.
// Build option AES_DECRYPT_EN enables the inverse pass (DEC state).
module aes128_selfcheck
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic              clk,
  input  logic              rst,
  aes128_selfcheck_if.slave bus
);

  localparam logic [3:0] RND_LAST = 4'(NR);
  localparam logic [3:0] RND_FIN  = 4'(NR + 1);

  fsm_e         st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] exp_q, exp_d;
  logic [127:0] enc_q, enc_d;
  logic         e_q, e_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [7:0]   rcon_w;
  logic [127:0] rk_next;
  logic [127:0] enc_rnd;

`ifdef AES_DECRYPT_EN
  logic [127:0] in_q, in_d;
  logic [127:0] dec_q, dec_d;
  logic         d_q, d_d;
  logic [127:0] rk_prev;
  logic [127:0] dec_rnd;
`endif

  // forward step uses Rcon[rnd-1]; the inverse step at the same
  // counter value undoes that very step, so one index serves both
  assign rcon_w = rcon(rnd_q - 4'd1);

  aes_key_step u_key (
    .rk_i   (rk_q),
    .rcon_i (rcon_w),
    .next_o (rk_next),
`ifdef AES_DECRYPT_EN
    .prev_o (rk_prev)
`else
    .prev_o ()
`endif
  );

  // forward round: SubBytes, ShiftRows, MixColumns (not last), AddRoundKey
  always_comb begin
    enc_rnd = shift_rows(sub_bytes(state_q));
    if (rnd_q != RND_LAST)
      enc_rnd = mix_columns(enc_rnd);
    enc_rnd = enc_rnd ^ rk_next;
  end

`ifdef AES_DECRYPT_EN
  // inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
  always_comb begin
    dec_rnd = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_prev;
    if (rnd_q != 4'd1)
      dec_rnd = inv_mix_columns(dec_rnd);
  end
`endif

  // all state, capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      rk_q    <= '0;
      exp_q   <= '0;
      enc_q   <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_DECRYPT_EN
      in_q    <= '0;
      dec_q   <= '0;
      d_q     <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      exp_q   <= exp_d;
      enc_q   <= enc_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AES_DECRYPT_EN
      in_q    <= in_d;
      dec_q   <= dec_d;
      d_q     <= d_d;
`endif
    end
  end

  // next-state: IDLE -> ENC -> (DEC ->) IDLE
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (bus.enable) st_d = ENC;
`ifdef AES_DECRYPT_EN
      ENC:  if (rnd_q == RND_FIN) st_d = DEC;
      DEC:  if (rnd_q == 4'd0) st_d = IDLE;
`else
      ENC:  if (rnd_q == RND_FIN) st_d = IDLE;
`endif
      default: st_d = IDLE;
    endcase
  end

  // datapath and result updates for each state
  always_comb begin
    rnd_d   = rnd_q;
    state_d = state_q;
    rk_d    = rk_q;
    exp_d   = exp_q;
    enc_d   = enc_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AES_DECRYPT_EN
    in_d    = in_q;
    dec_d   = dec_q;
    d_d     = d_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (bus.enable) begin
          exp_d   = bus.expected128;
          rk_d    = bus.key128;
          state_d = bus.in ^ bus.key128;
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
`ifdef AES_DECRYPT_EN
          in_d    = bus.in;
`endif
        end
      end
      ENC: begin
        if (rnd_q == RND_FIN) begin
          enc_d = state_q;
          e_d   = (state_q == exp_q);
`ifdef AES_DECRYPT_EN
          state_d = state_q ^ rk_q;
          rnd_d   = RND_LAST;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = enc_rnd;
          rk_d    = rk_next;
          rnd_d   = rnd_q + 4'd1;
        end
      end
`ifdef AES_DECRYPT_EN
      DEC: begin
        if (rnd_q == 4'd0) begin
          dec_d  = state_q;
          d_d    = (state_q == in_q);
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = dec_rnd;
          rk_d    = rk_prev;
          rnd_d   = rnd_q - 4'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.encrypted128 = enc_q;
  assign bus.e128         = e_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
`ifdef AES_DECRYPT_EN
  assign bus.decrypted128 = dec_q;
  assign bus.d128         = d_q;
`else
  assign bus.decrypted128 = '0;
  assign bus.d128         = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_selfcheck.sv
// tb_aes128_selfcheck: known-answer vectors plus start/reset corner cases.
// Expectations follow the AES_DECRYPT_EN build option.
module tb_aes128_selfcheck;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
    logic [127:0] ct;
    logic         e;
  } vec_t;

`ifdef AES_DECRYPT_EN
  localparam int D = 22;
`else
  localparam int D = 11;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  vec_t v [4];

  aes128_selfcheck_if bus ();

  aes128_selfcheck dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%h want=%h", n, a, e);
  endtask

  task automatic check_results(input string n, input int i);
    chk({n, "_enc"}, bus.encrypted128, v[i].ct);
    chk({n, "_e128"}, 128'(bus.e128), 128'(v[i].e));
`ifdef AES_DECRYPT_EN
    chk({n, "_dec"}, bus.decrypted128, v[i].pt);
    chk({n, "_d128"}, 128'(bus.d128), 128'd1);
`else
    chk({n, "_dec"}, bus.decrypted128, 128'd0);
    chk({n, "_d128"}, 128'(bus.d128), 128'd0);
`endif
  endtask

  task automatic run_vec(input int i);
    int spur = 0;
    string n = $sformatf("v%0d", i);
    @(negedge clk);
    bus.key128 = v[i].key;
    bus.in = v[i].pt;
    bus.expected128 = v[i].exp;
    bus.enable = 1'b1;
    for (int c = 0; c <= D + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.enable = 1'b0;
        chk({n, "_busy0"}, 128'(bus.busy), 128'd1);
      end
      if (c >= 1 && c < D && bus.done) spur++;
      if (c == 11) begin
        chk({n, "_enc11"}, bus.encrypted128, v[i].ct);
        chk({n, "_e11"}, 128'(bus.e128), 128'(v[i].e));
      end
      if (c == D) begin
        chk({n, "_done"}, 128'(bus.done), 128'd1);
        chk({n, "_busyD"}, 128'(bus.busy), 128'd0);
        check_results(n, i);
      end
      if (c == D + 1)
        chk({n, "_done_pulse"}, 128'(bus.done), 128'd0);
    end
    chk({n, "_early_done"}, 128'(spur), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int spur;
    v[0] = '{128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1};
    v[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734,
             128'h3925841d02dc09fbdc118597196a0b32,
             128'h3925841d02dc09fbdc118597196a0b32, 1'b1};
    v[2] = '{128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h0,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
    v[3] = '{128'h0, 128'h0,
             128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
             128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1};

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.in = '0;
    bus.key128 = '0;
    bus.expected128 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enc", bus.encrypted128, 128'd0);
    chk("rst_dec", bus.decrypted128, 128'd0);
    chk("rst_flags", {bus.e128, bus.d128, bus.busy, bus.done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(i);

    // enable toggling with operands changing mid-operation
    spur = 0;
    bus.key128 = v[0].key;
    bus.in = v[0].pt;
    bus.expected128 = v[0].exp;
    for (int c = 0; c <= D + 1; c++) begin
      @(negedge clk);
      bus.enable = (c % 2 == 0) && (c <= D);
      if (c >= 3) begin
        bus.in = ~v[0].pt;
        bus.key128 = ~v[0].key;
        bus.expected128 = '0;
      end
      @(posedge clk);
      #1;
      if (c >= 1 && c < D && bus.done) spur++;
      if (c == D) begin
        chk("tog_done", 128'(bus.done), 128'd1);
        check_results("tog", 0);
      end
      if (c == D + 1)
        chk("tog_no_restart", 128'(bus.busy), 128'd0);
    end
    chk("tog_early_done", 128'(spur), 128'd0);

    // enable held high: restart on the first idle cycle after done
    spur = 0;
    for (int c = 0; c <= 2 * D + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.key128 = v[0].key;
        bus.in = v[0].pt;
        bus.expected128 = v[0].exp;
        bus.enable = 1'b1;
      end
      if (c == D + 1) begin
        bus.key128 = v[1].key;
        bus.in = v[1].pt;
        bus.expected128 = v[1].exp;
      end
      if (c == D + 2) bus.enable = 1'b0;
      @(posedge clk);
      #1;
      if (c >= 1 && c < D && bus.done) spur++;
      if (c >= D + 2 && c < 2 * D + 1 && bus.done) spur++;
      if (c == D) begin
        chk("hold_done1", 128'(bus.done), 128'd1);
        check_results("hold1", 0);
      end
      if (c == D + 1) begin
        chk("hold_restart", 128'(bus.busy), 128'd1);
        chk("hold_pulse", 128'(bus.done), 128'd0);
      end
      if (c == 2 * D + 1) begin
        chk("hold_done2", 128'(bus.done), 128'd1);
        check_results("hold2", 1);
      end
    end
    chk("hold_early_done", 128'(spur), 128'd0);

    // reset in cycle 5 of ENC aborts and clears everything
    @(negedge clk);
    bus.key128 = v[1].key;
    bus.in = v[1].pt;
    bus.expected128 = v[1].exp;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_enc", bus.encrypted128, 128'd0);
    chk("abort_dec", bus.decrypted128, 128'd0);
    chk("abort_flags", {bus.e128, bus.d128, bus.busy, bus.done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
